// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared types and constants for the weight/image sequencer
package sw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sw_state_t;

  localparam int PE_LATENCY_DEFAULT = 4;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/sw_seq_counter.sv
// rtl/sw_seq_counter.sv - loadable wrap counter; the limit is captured on load
module sw_seq_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] last_value,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  logic [WIDTH-1:0] limit;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      limit <= '0;
    end else if (load) begin
      count <= '0;
      limit <= last_value;
    end else if (en) begin
      count <= terminal ? '0 : count + WIDTH'(1);
    end
  end

  assign terminal = (count == limit);

endmodule

// File: rtl/sw_seq_ctrl.sv
// rtl/sw_seq_ctrl.sv - group/image/weight beat sequencer with PE drain tracking
// Optional perf counters are built in when SW_SEQ_PERF_EN is defined.
module sw_seq_ctrl
  import sw_pkg::*;
#(
  parameter int NUM_PE            = 8,
  parameter int WEIGHT_ADDR_WIDTH = 13,
  parameter int IMAGE_ADDR_WIDTH  = 16,
  parameter int GROUP_WIDTH       = 8,
  parameter int PE_LATENCY        = PE_LATENCY_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [WEIGHT_ADDR_WIDTH-1:0] wgt_last,
  input  logic [IMAGE_ADDR_WIDTH-1:0]  img_last,
  input  logic [GROUP_WIDTH-1:0]       group_last,
  input  logic                         pipeline_full,
  output logic                         valid,
  output logic [WEIGHT_ADDR_WIDTH-1:0] addr_a,
  output logic [IMAGE_ADDR_WIDTH-1:0]  addr_b,
  output logic [GROUP_WIDTH-1:0]       group_idx,
  output logic                         last,
  output logic                         filters_finished,
  output logic                         pipeline_empty,
  output logic                         busy,
  output logic                         done,
  output logic [31:0]                  stall_cycles,
  output logic [31:0]                  active_cycles
);

  if (NUM_PE < 1 || PE_LATENCY < 1 || PE_LATENCY > 64) begin : g_param_check
    $error("sw_seq_ctrl: NUM_PE must be >= 1 and PE_LATENCY within 1..64");
  end

  // The top stage holds the beat that leaves the PE pipeline this cycle.
  localparam logic [PE_LATENCY-1:0] EXIT_STAGE = PE_LATENCY'(1) << (PE_LATENCY - 1);

  sw_state_t state, state_next;

  logic                         job_load;
  logic                         issue;
  logic                         group_end;
  logic                         job_end;
  logic                         w_term, i_term, g_term;
  logic [WEIGHT_ADDR_WIDTH-1:0] w_count;
  logic [WEIGHT_ADDR_WIDTH-1:0] weight_base;
  logic [WEIGHT_ADDR_WIDTH-1:0] w_words;
  logic [PE_LATENCY-1:0]        in_flight;

  assign job_load  = (state == ST_IDLE) && start;
  assign issue     = (state == ST_RUN) && !pipeline_full;
  assign group_end = issue && w_term && i_term;
  assign job_end   = group_end && g_term;

  sw_seq_counter #(.WIDTH(WEIGHT_ADDR_WIDTH)) u_weight_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (job_load),
    .last_value (wgt_last),
    .en         (issue),
    .count      (w_count),
    .terminal   (w_term)
  );

  sw_seq_counter #(.WIDTH(IMAGE_ADDR_WIDTH)) u_image_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (job_load),
    .last_value (img_last),
    .en         (issue && w_term),
    .count      (addr_b),
    .terminal   (i_term)
  );

  sw_seq_counter #(.WIDTH(GROUP_WIDTH)) u_group_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (job_load),
    .last_value (group_last),
    .en         (group_end),
    .count      (group_idx),
    .terminal   (g_term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Group stride accumulates W instead of multiplying group index by W.
  always_ff @(posedge clk) begin
    if (reset) begin
      weight_base <= '0;
      w_words     <= '0;
    end else if (job_load) begin
      weight_base <= '0;
      w_words     <= wgt_last + WEIGHT_ADDR_WIDTH'(1);
    end else if (group_end) begin
      weight_base <= weight_base + w_words;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_flight <= '0;
    end else begin
      in_flight <= (in_flight << 1) | PE_LATENCY'(issue);
    end
  end

  assign pipeline_empty   = !issue && ((in_flight & ~EXIT_STAGE) == '0);
  assign valid            = issue;
  assign addr_a           = weight_base + w_count;
  assign last             = job_end;
  assign filters_finished = group_end;

  always_comb begin
    state_next = state;
    done       = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (job_end) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pipeline_empty) begin
          state_next = ST_IDLE;
          done       = 1'b1;
        end else begin
          busy = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef SW_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset || job_load) begin
      stall_cycles  <= '0;
      active_cycles <= '0;
    end else begin
      if (state == ST_RUN && pipeline_full) stall_cycles <= sat_inc(stall_cycles);
      if (busy) active_cycles <= sat_inc(active_cycles);
    end
  end
`else
  assign stall_cycles  = '0;
  assign active_cycles = '0;
`endif

endmodule

// File: tb/tb_sw_seq_ctrl.sv
// tb/tb_sw_seq_ctrl.sv - self-checking bench for sw_seq_ctrl
module tb_sw_seq_ctrl;

  localparam int WA  = 13;
  localparam int IA  = 16;
  localparam int GW  = 8;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [WA-1:0] wgt_last = '0;
  logic [IA-1:0] img_last = '0;
  logic [GW-1:0] group_last = '0;
  logic          pipeline_full = 1'b0;
  logic          valid;
  logic [WA-1:0] addr_a;
  logic [IA-1:0] addr_b;
  logic [GW-1:0] group_idx;
  logic          last, filters_finished, pipeline_empty, busy, done;
  logic [31:0]   stall_cycles, active_cycles;

  int errors = 0;
  int checks = 0;

  sw_seq_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .wgt_last         (wgt_last),
    .img_last         (img_last),
    .group_last       (group_last),
    .pipeline_full    (pipeline_full),
    .valid            (valid),
    .addr_a           (addr_a),
    .addr_b           (addr_b),
    .group_idx        (group_idx),
    .last             (last),
    .filters_finished (filters_finished),
    .pipeline_empty   (pipeline_empty),
    .busy             (busy),
    .done             (done),
    .stall_cycles     (stall_cycles),
    .active_cycles    (active_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int a;
    int b;
    int g;
    bit lst;
    bit ff;
  } beat_t;

  typedef struct {
    int wl;
    int il;
    int gl;
    int mode;
    bit poke;
    int exp_beats;
    int exp_span;
    int exp_stall;
  } vec_t;

  beat_t exp_q[$];
  int    cap_a[$];
  bit    cap_ff[$];

  // Reference sequence straight from the loop nest: group outer, image, weight inner.
  task automatic build_model(input int wl, input int il, input int gl);
    exp_q.delete();
    for (int g = 0; g <= gl; g++)
      for (int i = 0; i <= il; i++)
        for (int w = 0; w <= wl; w++)
          exp_q.push_back('{(g * (wl + 1) + w) % (1 << WA), i, g,
                             (g == gl && i == il && w == wl), (i == il && w == wl)});
  endtask

  // mode 0: never full, 1: full on every second cycle, 2: random full
  task automatic run_job(input int wl, input int il, input int gl, input int mode,
                         input bit poke, output int n_beats, output int span);
    int c, k, first_c, last_c, done_c, ndone, stall_exp, last_beat_c, budget;
    bit recent;
    build_model(wl, il, gl);
    cap_a.delete();
    cap_ff.delete();
    @(posedge clk); #1;
    wgt_last = WA'(wl); img_last = IA'(il); group_last = GW'(gl);
    start = 1'b1; pipeline_full = 1'b0;
    #1;
    chk("idle_valid", valid, 0);
    chk("idle_empty", pipeline_empty, 1);
    @(posedge clk); #1;
    start = 1'b0;
    wgt_last = WA'($urandom); img_last = IA'($urandom); group_last = GW'($urandom);
    c = 1; k = 0; first_c = -1; last_c = -1; done_c = -1; ndone = 0;
    stall_exp = 0; last_beat_c = -1000;
    budget = exp_q.size() * 4 + 40;
    while (c < budget && (done_c < 0 || c < done_c + 3)) begin
      case (mode)
        1:       pipeline_full = (c % 2 == 0);
        2:       pipeline_full = ($urandom_range(0, 2) == 0);
        default: pipeline_full = 1'b0;
      endcase
      start = poke && (c == 3 || (last_c >= 0 && c == last_c + LAT));
      #1;
      if (last_c < 0 && pipeline_full) stall_exp++;
      recent = (c - last_beat_c) < LAT;
      chk("pipeline_empty", pipeline_empty, !valid && !recent);
      if (valid) begin
        if (k < exp_q.size()) begin
          chk("addr_a", addr_a, exp_q[k].a);
          chk("addr_b", addr_b, exp_q[k].b);
          chk("group_idx", group_idx, exp_q[k].g);
          chk("last", last, exp_q[k].lst);
          chk("filters_finished", filters_finished, exp_q[k].ff);
        end else begin
          chk("extra_beat", 1, 0);
        end
        cap_a.push_back(int'(addr_a));
        cap_ff.push_back(filters_finished);
        if (first_c < 0) first_c = c;
        last_beat_c = c;
        k++;
        if (k == exp_q.size() && last_c < 0) last_c = c;
      end else begin
        chk("quiet_flags", {last, filters_finished}, 0);
      end
      if (done) begin
        ndone++;
        if (done_c < 0) done_c = c;
        chk("busy_at_done", busy, 0);
      end
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    pipeline_full = 1'b0;
    chk("beat_count", k, exp_q.size());
    chk("done_pulses", ndone, 1);
    chk("done_latency", done_c - last_c, LAT);
`ifdef SW_SEQ_PERF_EN
    chk("stall_cycles", stall_cycles, stall_exp);
    chk("active_cycles", active_cycles, done_c - 1);
`else
    chk("stall_cycles_off", stall_cycles, 0);
    chk("active_cycles_off", active_cycles, 0);
`endif
    n_beats = k;
    span = (last_c >= 0 && first_c >= 0) ? last_c - first_c + 1 : 0;
  endtask

  vec_t tbl[7];
  int   lit_a[12];
  int   nb, sp, dn, vn;

  initial begin
    tbl[0] = '{2, 1, 1, 0, 1'b0, 12, 12, 0};
    tbl[1] = '{2, 1, 1, 1, 1'b0, 12, 23, 11};
    tbl[2] = '{0, 0, 0, 0, 1'b0, 1, 1, 0};
    tbl[3] = '{2, 1, 1, 0, 1'b1, 12, 12, 0};
    tbl[4] = '{3, 0, 2, 1, 1'b0, 12, 23, 11};
    tbl[5] = '{0, 4, 0, 0, 1'b0, 5, 5, 0};
    tbl[6] = '{8191, 0, 1, 0, 1'b0, 16384, 16384, 0};
    lit_a = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};

    // Reset with start and garbage inputs applied
    reset = 1'b1; start = 1'b1; pipeline_full = 1'b1;
    wgt_last = 13'd5; img_last = 16'd7; group_last = 8'd3;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", valid, 0);
    chk("rst_addr_a", addr_a, 0);
    chk("rst_addr_b", addr_b, 0);
    chk("rst_group", group_idx, 0);
    chk("rst_flags", {last, filters_finished, busy, done}, 0);
    chk("rst_empty", pipeline_empty, 1);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_active", active_cycles, 0);
    start = 1'b0; pipeline_full = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    for (int t = 0; t < 7; t++) begin
      run_job(tbl[t].wl, tbl[t].il, tbl[t].gl, tbl[t].mode, tbl[t].poke, nb, sp);
      chk("tbl_beats", nb, tbl[t].exp_beats);
      chk("tbl_span", sp, tbl[t].exp_span);
`ifdef SW_SEQ_PERF_EN
      chk("tbl_stall", stall_cycles, tbl[t].exp_stall);
`endif
      if (t == 0 && cap_a.size() == 12) begin
        for (int j = 0; j < 12; j++) begin
          chk("lit_addr_a", cap_a[j], lit_a[j]);
          chk("lit_ff", cap_ff[j], (j == 5 || j == 11));
        end
      end
    end

    for (int r = 0; r < 6; r++) begin
      run_job($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3), 2, 1'b0, nb, sp);
    end

    // Reset on beat 5 aborts the job without a done pulse
    @(posedge clk); #1;
    wgt_last = 13'd2; img_last = 16'd1; group_last = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nb = 0;
    for (int c = 0; c < 20 && nb < 5; c++) begin
      #1;
      if (valid) nb++;
      if (nb < 5) begin
        @(posedge clk); #1;
      end
    end
    chk("abort_beat5_reached", nb, 5);
    reset = 1'b1;
    @(posedge clk); #2;
    chk("abort_valid", valid, 0);
    chk("abort_empty", pipeline_empty, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_stall", stall_cycles, 0);
    chk("abort_active", active_cycles, 0);
    reset = 1'b0;
    dn = 0; vn = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #2;
      if (done) dn++;
      if (valid) vn++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_no_valid", vn, 0);

    // A clean job after the abort still runs normally
    run_job(2, 1, 1, 0, 1'b0, nb, sp);
    chk("post_abort_beats", nb, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
